match_sched: RTL
================

# match_sched

Match-level scheduler that sits above the rally/ball controller in the ping-pong game box. It decides which player may serve, and applies the serve-rotation rules: two serves each, then alternating every point at deuce. It also accumulates points into games and games into a match. The rally controller reports who won each point; this block gates serve keys, tracks scores, and freezes play at game or match end.

## Interface
- POINTS_TO_WIN, default 11: points needed to win a game (win-by-2 applies); legal range 3..29.
- SERVES_PER_TURN, default 2: consecutive serves per player before service changes (non-deuce).
- GAMES_TO_WIN, default 2: games needed to win the match (best of 3); legal range 1..3.
- PAUSE_CYCLES, default 1000: clk cycles of frozen play between games; must be ≥1.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; begins a match from IDLE or MATCH_END.
- serve_start  input  1  one-cycle pulse from the rally controller; the enabled server has launched the ball.
- point_p1  input  1  one-cycle pulse; player 1 won the rally.
- point_p2  input  1  one-cycle pulse; player 2 won the rally.
- serve_en_p1  output  1  player 1 may serve.
- serve_en_p2  output  1  player 2 may serve.
- server  output  1  current server (0 = player 1, 1 = player 2).
- score_p1, score_p2  output  5  current game points.
- games_p1, games_p2  output  2  games won in this match.
- game_won  output  1  one-cycle pulse when a game is decided.
- match_over  output  1  high while in MATCH_END.
- winner  output  1  winner of the last decided game/match (0 = player 1).

## Operation
- States: IDLE, SERVE_WAIT, RALLY, CHECK, GAME_END, MATCH_END.
- Reset values: state IDLE; all scores and games 0; server 0; serve_cnt 0; first_server 0; winner 0; all pulse/enable outputs 0.
- IDLE: waits for start, then goes to SERVE_WAIT. All other inputs are ignored.
- SERVE_WAIT:
  - serve_en_p1 = (server == 0) and serve_en_p2 = (server == 1); both are 0 in every other state.
  - serve_start moves the block to RALLY.
  - point pulses are ignored in this state.
- RALLY, exactly one point pulse: increment that player's score and go to CHECK.
- RALLY, both point pulses in the same cycle: treated as a let. No score change, serve_cnt unchanged, back to SERVE_WAIT with the same server.
- RALLY, serve_start: ignored.
- CHECK, game decided: a game is won when the leader's score is ≥ POINTS_TO_WIN and leads by ≥2.
  - Pulse game_won, set winner, increment that player's games.
  - Go to MATCH_END if the new games count equals GAMES_TO_WIN, else to GAME_END.
- CHECK, deuce clamp: if both scores are ≥ POINTS_TO_WIN, decrement both by 1. The difference is preserved and scores never exceed POINTS_TO_WIN+1.
- CHECK, service change:
  - Deuce (both scores ≥ POINTS_TO_WIN−1, evaluated after the clamp): toggle server every point; serve_cnt = 0.
  - Otherwise: increment serve_cnt; on reaching SERVES_PER_TURN, toggle server and reset serve_cnt to 0.
  - Then go to SERVE_WAIT.
- GAME_END:
  - Count PAUSE_CYCLES.
  - On expiry: clear both scores and serve_cnt, toggle first_server, set server = first_server, go to SERVE_WAIT.
  - The first serve alternates game to game.
- MATCH_END:
  - Scores, games and winner are held; match_over = 1.
  - start clears scores, games, serve_cnt, first_server and server to 0, then goes to SERVE_WAIT.
- start in SERVE_WAIT, RALLY, CHECK or GAME_END is ignored. Only rst aborts a match.
- rst mid-operation: immediate return to the reset values, regardless of state or pause count.

## Timing
- Point latency: point pulse sampled at edge k gives the updated score and state CHECK after k. After edge k+1: new server, state SERVE_WAIT/GAME_END/MATCH_END, and a game_won pulse for the single cycle k+1..k+2.
- serve_en_* is decoded from registered state and server, with no input-to-output combinational path. It becomes valid the cycle after the state is entered.
- serve_start at edge k: serve_en_* deasserts after k.
- GAME_END: exactly PAUSE_CYCLES cycles in the state, then SERVE_WAIT.
- Point pulses are assumed to be one cycle wide and already synchronous to clk. Wider pulses are only counted once because CHECK is a non-accepting state; a pulse still high after returning to RALLY counts again.

## Structure
- Shared package match_pkg holds:
  - the one-hot state encoding (6 bits) and state constants;
  - the PLAYER1/PLAYER2 encoding (0/1);
  - a score width constant of 5 and a games width constant of 2.
- One sub-module, serve_rotator. It owns serve_cnt, server and first_server, with inputs point_done, deuce, let, new_game and new_match. The main module keeps the FSM, score/games registers and pause counter.

## Test plan
- Reset then start with default parameters: serve_en_p1 = 1 after one cycle. serve_start followed by point_p1 gives score_p1 = 1 and server still 0. After a second point, server = 1 and serve_en_p2 asserts.
- Drive 11–0 to player 1 → game_won pulses once, games_p1 = 1, then 1000 cycles in GAME_END. After the pause, scores = 0 and server = 1 (first server alternated).
- Bring the score to 10–10, then alternate points to reach 12–11 → the clamp holds the score at 11–10 with no game_won. Server toggles every point. Two consecutive points to player 2 from 10–10 then give 12–10 → game_won with winner = 1.
- point_p1 and point_p2 in the same cycle during RALLY → scores unchanged, server unchanged, serve_cnt unchanged, back to SERVE_WAIT.
- Play to games_p2 = 2 → match_over = 1 and all further point/serve inputs are ignored. start clears everything to 0 with serve_en_p1 = 1.
- Assert rst mid-GAME_END and mid-RALLY → all outputs return to reset values on the same edge, without waiting for clk.

Source files
------------

// File: rtl/match_pkg.sv
// Shared encodings for the match scheduler: FSM states, player ids, field widths.
package match_pkg;

  localparam int SCORE_W = 5;
  localparam int GAMES_W = 2;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

  // One-hot match FSM states
  typedef enum logic [5:0] {
    S_IDLE       = 6'b000001,
    S_SERVE_WAIT = 6'b000010,
    S_RALLY      = 6'b000100,
    S_CHECK      = 6'b001000,
    S_GAME_END   = 6'b010000,
    S_MATCH_END  = 6'b100000
  } state_t;

endpackage

// File: rtl/match_sched_serve_rotator.sv
// Serve rotation: tracks serves in the current turn, the current server and
// who opened the current game.
module serve_rotator
  import match_pkg::*;
#(
  parameter int SERVES_PER_TURN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic point_done,
  input  logic deuce,
  input  logic let_point,
  input  logic new_game,
  input  logic new_match,
  output logic server
);

  localparam int CW = $clog2(SERVES_PER_TURN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVES_PER_TURN);

  logic [CW-1:0] serve_cnt;
  logic [CW-1:0] cnt_next;
  logic          first_server;

  // Next serve count within the current turn
  always_comb begin
    cnt_next = serve_cnt + 1'b1;
  end

  // Rotation update: match reset, game opening alternation, let hold, per-point change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serve_cnt    <= '0;
      server       <= PLAYER1;
      first_server <= PLAYER1;
    end else if (new_match) begin
      serve_cnt    <= '0;
      server       <= PLAYER1;
      first_server <= PLAYER1;
    end else if (new_game) begin
      serve_cnt    <= '0;
      first_server <= ~first_server;
      server       <= ~first_server;
    end else if (let_point) begin
      serve_cnt <= serve_cnt;
      server    <= server;
    end else if (point_done) begin
      if (deuce) begin
        server    <= ~server;
        serve_cnt <= '0;
      end else if (cnt_next == CNT_LAST) begin
        server    <= ~server;
        serve_cnt <= '0;
      end else begin
        serve_cnt <= cnt_next;
      end
    end
  end

endmodule

// File: rtl/match_sched.sv
// Match-level scheduler: gates serve keys, scores points into games and games
// into a match, and freezes play between games and at match end.
module match_sched
  import match_pkg::*;
#(
  parameter int POINTS_TO_WIN   = 11,
  parameter int SERVES_PER_TURN = 2,
  parameter int GAMES_TO_WIN    = 2,
  parameter int PAUSE_CYCLES    = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               serve_start,
  input  logic               point_p1,
  input  logic               point_p2,
  output logic               serve_en_p1,
  output logic               serve_en_p2,
  output logic               server,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [GAMES_W-1:0] games_p1,
  output logic [GAMES_W-1:0] games_p2,
  output logic               game_won,
  output logic               match_over,
  output logic               winner
);

  localparam int PW = $clog2(PAUSE_CYCLES + 1);
  localparam logic [SCORE_W:0]   P_WIN      = (SCORE_W + 1)'(POINTS_TO_WIN);
  localparam logic [SCORE_W:0]   P_DEUCE    = (SCORE_W + 1)'(POINTS_TO_WIN - 1);
  localparam logic [GAMES_W-1:0] G_WIN      = GAMES_W'(GAMES_TO_WIN);
  localparam logic [PW-1:0]      PAUSE_LAST = PW'(PAUSE_CYCLES - 1);

  state_t        state;
  logic [PW-1:0] pause_cnt;

  logic [SCORE_W:0] s1w, s2w;
  logic p1_wins, p2_wins, decided, clamp, deuce;
  logic point_done, let_point, new_game, new_match;

  // Game decision, deuce detection and rotator strobes from registered scores/state
  always_comb begin
    s1w        = {1'b0, score_p1};
    s2w        = {1'b0, score_p2};
    p1_wins    = (s1w >= P_WIN) && (s1w >= s2w + 6'd2);
    p2_wins    = (s2w >= P_WIN) && (s2w >= s1w + 6'd2);
    decided    = p1_wins || p2_wins;
    clamp      = (s1w >= P_WIN) && (s2w >= P_WIN);
    // both >= P-1 before the clamp is equivalent to both >= P-1 after it
    deuce      = (s1w >= P_DEUCE) && (s2w >= P_DEUCE);
    point_done = (state == S_CHECK) && !decided;
    let_point  = (state == S_RALLY) && point_p1 && point_p2;
    new_game   = (state == S_GAME_END) && (pause_cnt == PAUSE_LAST);
    new_match  = (state == S_MATCH_END) && start;
  end

  // Serve keys and match flag decoded from registered state only
  assign serve_en_p1 = (state == S_SERVE_WAIT) && (server == PLAYER1);
  assign serve_en_p2 = (state == S_SERVE_WAIT) && (server == PLAYER2);
  assign match_over  = (state == S_MATCH_END);

  serve_rotator #(
    .SERVES_PER_TURN(SERVES_PER_TURN)
  ) u_rot (
    .clk       (clk),
    .rst       (rst),
    .point_done(point_done),
    .deuce     (deuce),
    .let_point (let_point),
    .new_game  (new_game),
    .new_match (new_match),
    .server    (server)
  );

  // Match FSM with score, games, winner and pause counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      score_p1  <= '0;
      score_p2  <= '0;
      games_p1  <= '0;
      games_p2  <= '0;
      winner    <= PLAYER1;
      game_won  <= 1'b0;
      pause_cnt <= '0;
    end else begin
      game_won <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) state <= S_SERVE_WAIT;
        end
        S_SERVE_WAIT: begin
          if (serve_start) state <= S_RALLY;
        end
        S_RALLY: begin
          if (point_p1 && point_p2) begin
            state <= S_SERVE_WAIT;
          end else if (point_p1) begin
            score_p1 <= score_p1 + 1'b1;
            state    <= S_CHECK;
          end else if (point_p2) begin
            score_p2 <= score_p2 + 1'b1;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (decided) begin
            game_won  <= 1'b1;
            winner    <= p2_wins;
            pause_cnt <= '0;
            if (p2_wins) begin
              games_p2 <= games_p2 + 1'b1;
              state    <= (games_p2 + 1'b1 == G_WIN) ? S_MATCH_END : S_GAME_END;
            end else begin
              games_p1 <= games_p1 + 1'b1;
              state    <= (games_p1 + 1'b1 == G_WIN) ? S_MATCH_END : S_GAME_END;
            end
          end else begin
            if (clamp) begin
              score_p1 <= score_p1 - 1'b1;
              score_p2 <= score_p2 - 1'b1;
            end
            state <= S_SERVE_WAIT;
          end
        end
        S_GAME_END: begin
          if (pause_cnt == PAUSE_LAST) begin
            score_p1 <= '0;
            score_p2 <= '0;
            state    <= S_SERVE_WAIT;
          end else begin
            pause_cnt <= pause_cnt + 1'b1;
          end
        end
        S_MATCH_END: begin
          if (start) begin
            score_p1 <= '0;
            score_p2 <= '0;
            games_p1 <= '0;
            games_p2 <= '0;
            state    <= S_SERVE_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
